wr_pntr_full: RTL and testbench
===============================

WR_PNTR_FULL -- requirements
Module: wr_pntr_full

Interface
REQ-001 SHALL have parameter AWIDTH, default 3, giving FIFO depth 2**AWIDTH; legal values are AWIDTH >= 2.
REQ-002 SHALL have port wr_clk_i, input, 1 bit: write-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port aclr_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port wr_req_i, input, 1 bit: write request from the FIFO user.
REQ-005 SHALL have port rd_pntr_gray_i, input, AWIDTH+1 bits: read pointer in Gray code, already synchronized into wr_clk_i by the r2w synchronizer.
REQ-006 SHALL have port wr_en_o, output, 1 bit: write strobe to the dual-port memory.
REQ-007 SHALL have port wr_addr_o, output, AWIDTH bits: memory write address.
REQ-008 SHALL have port wr_pntr_gray_o, output, AWIDTH+1 bits: registered Gray write pointer, sent to the w2r synchronizer.
REQ-009 SHALL have port wr_full_o, output, 1 bit: registered full flag.
REQ-010 SHALL have port wr_usedw_o, output, AWIDTH+1 bits: write-side fill level; present only under FIFO_WR_USEDW_EN.

Function
REQ-011 SHALL hold a binary write pointer wr_bin of AWIDTH+1 bits and a Gray pointer wr_gray of AWIDTH+1 bits.
REQ-012 SHALL drive wr_en_o combinationally as wr_req_i AND NOT wr_full_o.
REQ-013 SHALL drive wr_addr_o as wr_bin[AWIDTH-1:0], with no extra latency.
REQ-014 SHALL compute wr_bin_next as wr_bin + wr_en_o, modulo 2**(AWIDTH+1), wrapping from all-ones to zero with no other effect.
REQ-015 SHALL compute wr_gray_next as wr_bin_next XOR (wr_bin_next >> 1).
REQ-016 SHALL register wr_bin <= wr_bin_next and wr_gray <= wr_gray_next every cycle; wr_pntr_gray_o = wr_gray.
REQ-017 SHALL register wr_full_o <= (wr_gray_next == {~rd_pntr_gray_i[AWIDTH:AWIDTH-1], rd_pntr_gray_i[AWIDTH-2:0]}).
REQ-018 SHALL assert full on the same edge that accepts the write filling the last location; it SHALL NOT be a cycle late.
REQ-019 SHALL ignore wr_req_i while full: no pointer change and wr_en_o = 0; this is not an error.
REQ-020 Full deassertion SHALL occur on the first edge after rd_pntr_gray_i changes; the two-cycle r2w delay makes full pessimistic and never optimistic.
REQ-021 If a write and a read-pointer change coincide, full SHALL be evaluated from wr_gray_next and the current rd_pntr_gray_i only.
REQ-022 wr_gray SHALL change by at most one bit per cycle.

Reset
REQ-023 While aclr_i = 1, SHALL force wr_bin = 0, wr_gray = 0, wr_full_o = 0 and wr_usedw_o = 0 immediately, independent of wr_clk_i.
REQ-024 As a consequence, wr_en_o follows wr_req_i during reset; the memory write-side owner SHALL qualify it with reset.
REQ-025 Reset asserted mid-operation SHALL discard all pointer state; the read side is reset by the same aclr_i.
REQ-026 The first pointer update SHALL occur on the first wr_clk_i rising edge after aclr_i falls.

Configuration
REQ-027 With FIFO_WR_USEDW_EN defined: wr_usedw_o <= wr_bin_next - gray2bin(rd_pntr_gray_i), modulo 2**(AWIDTH+1), registered.
REQ-028 wr_usedw_o range SHALL be 0..2**AWIDTH, and it SHALL equal 2**AWIDTH exactly when wr_full_o = 1.
REQ-029 With FIFO_WR_USEDW_EN undefined, the wr_usedw_o port and the gray2bin logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package fifo_pkg SHALL hold functions bin2gray and gray2bin, parameterized by width; they are shared with the read-side pointer/empty block.
REQ-031 No sub-module SHALL be used; the block is one flat module.

Verification (AWIDTH=3)
REQ-032 Reset: aclr_i=1 pulse between edges -> wr_pntr_gray_o=0000, wr_full_o=0, wr_addr_o=000, wr_usedw_o=0 immediately.
REQ-033 Fill: rd_pntr_gray_i=0000, 8 consecutive wr_req_i -> after 8th edge wr_full_o=1, wr_pntr_gray_o=1100, wr_usedw_o=8; 9th request gives wr_en_o=0 and the pointer holds.
REQ-034 Release: from full, set rd_pntr_gray_i=0001 -> next edge wr_full_o=0, wr_usedw_o=7; next request writes address 000.
REQ-035 Wrap: 20 writes with rd_pntr_gray_i tracking wr_pntr_gray_o two cycles late -> pointer passes 1000->0000 Gray wrap, full never asserts, one bit changes per cycle.
REQ-036 Simultaneous: full, wr_req_i=1, rd_pntr_gray_i advances same cycle -> wr_en_o=0 that cycle, full clears next edge, write accepted the cycle after.
REQ-037 Mid-op reset: aclr_i asserted after 5 writes -> outputs zero immediately; after release, 8 writes refill to full.

Source files
------------

// File: rtl/fifo_pkg.sv
//------------------------------------------------------------------------------
// fifo_pkg -- Gray/binary pointer conversion shared by the FIFO pointer blocks.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int FIFO_PTR_MAXW = 32;

  typedef logic [FIFO_PTR_MAXW-1:0] fifo_ptr_t;

  // Operands are zero-extended pointers, so one implementation serves any
  // pointer width up to FIFO_PTR_MAXW; the caller truncates the result.
  function automatic fifo_ptr_t bin2gray(input fifo_ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic fifo_ptr_t gray2bin(input fifo_ptr_t g);
    fifo_ptr_t b;
    b[FIFO_PTR_MAXW-1] = g[FIFO_PTR_MAXW-1];
    for (int i = FIFO_PTR_MAXW-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wr_pntr_full.sv
//------------------------------------------------------------------------------
// wr_pntr_full -- async-FIFO write pointer and registered full flag.
// Optional write-side fill level under macro FIFO_WR_USEDW_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wr_pntr_full
  import fifo_pkg::*;
#(
  parameter int AWIDTH = 3
) (
  input  logic              wr_clk_i,
  input  logic              aclr_i,
  input  logic              wr_req_i,
  input  logic [AWIDTH:0]   rd_pntr_gray_i,
  output logic              wr_en_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic [AWIDTH:0]   wr_pntr_gray_o,
`ifdef FIFO_WR_USEDW_EN
  output logic [AWIDTH:0]   wr_usedw_o,
`endif
  output logic              wr_full_o
);

  logic [AWIDTH:0] wr_bin_q;
  logic [AWIDTH:0] wr_bin_d;
  logic [AWIDTH:0] wr_gray_q;
  logic [AWIDTH:0] wr_gray_d;
  logic            wr_full_q;
  logic            wr_full_d;
  logic [AWIDTH:0] rd_gray_full_cmp;

  assign wr_en_o        = wr_req_i & ~wr_full_q;
  assign wr_addr_o      = wr_bin_q[AWIDTH-1:0];
  assign wr_pntr_gray_o = wr_gray_q;
  assign wr_full_o      = wr_full_q;

  assign wr_bin_d  = wr_bin_q + {{AWIDTH{1'b0}}, wr_en_o};
  assign wr_gray_d = (AWIDTH+1)'(bin2gray(fifo_ptr_t'(wr_bin_d)));

  // Inverting the two Gray MSBs of the read pointer yields the Gray code of
  // (read pointer + depth): the write pointer one full lap ahead.
  assign rd_gray_full_cmp = {~rd_pntr_gray_i[AWIDTH:AWIDTH-1], rd_pntr_gray_i[AWIDTH-2:0]};
  assign wr_full_d        = (wr_gray_d == rd_gray_full_cmp);

  always_ff @(posedge wr_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      wr_full_q <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      wr_full_q <= wr_full_d;
    end
  end

`ifdef FIFO_WR_USEDW_EN
  logic [AWIDTH:0] rd_bin;
  logic [AWIDTH:0] wr_usedw_d;
  logic [AWIDTH:0] wr_usedw_q;

  assign rd_bin     = (AWIDTH+1)'(gray2bin(fifo_ptr_t'(rd_pntr_gray_i)));
  assign wr_usedw_d = wr_bin_d - rd_bin;
  assign wr_usedw_o = wr_usedw_q;

  always_ff @(posedge wr_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      wr_usedw_q <= '0;
    end else begin
      wr_usedw_q <= wr_usedw_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wr_pntr_full.sv
//------------------------------------------------------------------------------
// tb_wr_pntr_full -- directed bench with an occupancy-count reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wr_pntr_full;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          aclr = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW:0]   rd_gray = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_gray;
  logic          wr_full;
`ifdef FIFO_WR_USEDW_EN
  logic [AW:0]   wr_usedw;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wr_pntr_full #(.AWIDTH(AW)) dut (
    .wr_clk_i       (clk),
    .aclr_i         (aclr),
    .wr_req_i       (wr_req),
    .rd_pntr_gray_i (rd_gray),
    .wr_en_o        (wr_en),
    .wr_addr_o      (wr_addr),
    .wr_pntr_gray_o (wr_gray),
`ifdef FIFO_WR_USEDW_EN
    .wr_usedw_o     (wr_usedw),
`endif
    .wr_full_o      (wr_full)
  );

  function automatic int g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  function automatic logic [AW:0] b2g(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: count of accepted writes and occupancy vs. read count.
  int m_wcnt = 0;
  int m_full = 0;
  int m_used = 0;

  always @(posedge clk or posedge aclr) begin
    int en, nxt, occ;
    if (aclr) begin
      m_wcnt <= 0;
      m_full <= 0;
      m_used <= 0;
    end else begin
      en  = (wr_req && m_full == 0) ? 1 : 0;
      nxt = (m_wcnt + en) % MOD;
      occ = (nxt - g2b(rd_gray) + MOD) % MOD;
      m_wcnt <= nxt;
      m_full <= (occ == DEPTH) ? 1 : 0;
      m_used <= occ;
    end
  end

  logic [AW:0] prev_gray = '0;

  always @(negedge clk) begin
    if (!aclr) begin
      chk("cyc_gray", int'(wr_gray), int'(b2g(m_wcnt)));
      chk("cyc_full", int'(wr_full), m_full);
      chk("cyc_addr", int'(wr_addr), m_wcnt % DEPTH);
      chk("cyc_wren", int'(wr_en), (wr_req && m_full == 0) ? 1 : 0);
      chk("cyc_onebit", ($countones(wr_gray ^ prev_gray) <= 1) ? 1 : 0, 1);
`ifdef FIFO_WR_USEDW_EN
      chk("cyc_usedw", int'(wr_usedw), m_used);
      chk("cyc_usedw_full", (int'(wr_usedw) == DEPTH) ? 1 : 0, int'(wr_full));
`endif
    end
    prev_gray = wr_gray;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gray"}, int'(wr_gray), 0);
    chk({tag, "_full"}, int'(wr_full), 0);
    chk({tag, "_addr"}, int'(wr_addr), 0);
`ifdef FIFO_WR_USEDW_EN
    chk({tag, "_usedw"}, int'(wr_usedw), 0);
`endif
  endtask

  initial begin
    logic [AW:0] d1, d2;

    // Reset pulse between edges
    #2 aclr = 1'b1;
    #1 chk_zero("rst");
    tick();
    aclr = 1'b0;

    // Fill with stalled reader
    rd_gray = '0;
    wr_req  = 1'b1;
    repeat (DEPTH) tick();
    chk("fill_full", int'(wr_full), 1);
    chk("fill_gray", int'(wr_gray), 'b1100);
`ifdef FIFO_WR_USEDW_EN
    chk("fill_usedw", int'(wr_usedw), 8);
`endif
    chk("fill_wren9", int'(wr_en), 0);
    tick();
    chk("fill_hold", int'(wr_gray), 'b1100);

    // Release by one read
    wr_req  = 1'b0;
    rd_gray = 4'b0001;
    tick();
    chk("rel_full", int'(wr_full), 0);
`ifdef FIFO_WR_USEDW_EN
    chk("rel_usedw", int'(wr_usedw), 7);
`endif
    wr_req = 1'b1;
    #1;
    chk("rel_addr", int'(wr_addr), 0);
    chk("rel_wren", int'(wr_en), 1);
    tick();
    chk("rel_refull", int'(wr_full), 1);

    // Write request and read advance in the same cycle
    rd_gray = 4'b0011;
    #1;
    chk("sim_wren0", int'(wr_en), 0);
    tick();
    chk("sim_clear", int'(wr_full), 0);
    chk("sim_wren1", int'(wr_en), 1);
    tick();
    chk("sim_gray", int'(wr_gray), 'b1111);
    chk("sim_full", int'(wr_full), 1);

    // Wrap with reader trailing two cycles
    wr_req = 1'b0;
    aclr   = 1'b1;
    rd_gray = '0;
    #1 chk_zero("wrst");
    tick();
    aclr   = 1'b0;
    wr_req = 1'b1;
    d1 = '0;
    d2 = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rd_gray = d2;
      d2 = d1;
      d1 = wr_gray;
      if (wr_full) chk("wrap_nofull", 1, 0);
    end
    chk("wrap_gray", int'(wr_gray), int'(b2g(20)));
    chk("wrap_full", int'(wr_full), 0);

    // Mid-operation reset then refill
    wr_req = 1'b0;
    aclr   = 1'b1;
    rd_gray = '0;
    tick();
    aclr   = 1'b0;
    wr_req = 1'b1;
    repeat (5) tick();
    chk("mid_gray5", int'(wr_gray), 'b0111);
    #2 aclr = 1'b1;
    #1 chk_zero("mid");
    chk("mid_wren_rst", int'(wr_en), 1);
    tick();
    aclr = 1'b0;
    repeat (DEPTH) tick();
    chk("mid_refull", int'(wr_full), 1);
    chk("mid_gray", int'(wr_gray), 'b1100);

    wr_req = 1'b0;
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
